// File: rtl/pattern_sequence_detector.sv
// Streaming detector for a programmable symbol pattern.
// A KMP failure table is built after each commit, then symbols are matched.
module pattern_sequence_detector #(
  parameter  int CHAR_W  = 8,
  parameter  int MAX_LEN = 16,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = $clog2(MAX_LEN),
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [CHAR_W-1:0] cfg_char,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_commit,
  input  logic              overlap_en,
  input  logic              in_valid,
  input  logic [CHAR_W-1:0] in_char,
  output logic              in_ready,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              cfg_error,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUILD,
    RUN
  } state_t;

  state_t state, state_d;

  logic [CHAR_W-1:0] pat  [MAX_LEN];
  logic [IDX_W-1:0]  fail [MAX_LEN];

  logic [LEN_W-1:0]  len, i;
  logic [IDX_W-1:0]  k, j;
  logic              stall;
  logic [CHAR_W-1:0] held;

  logic              cfg_ok, step, eq_b, eq_r, last, active;
  logic [CHAR_W-1:0] c;
  logic [IDX_W-1:0]  fail_end;

  always_comb begin
    cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    step     = (state == BUILD) && (i != len);
    eq_b     = pat[IDX_W'(i)] == pat[k];
    c        = stall ? held : in_char;
    eq_r     = c == pat[j];
    last     = (LEN_W'(j) + LEN_W'(1)) == len;
    fail_end = fail[IDX_W'(len - LEN_W'(1))];
  end

  always_comb begin
    state_d  = state;
    in_ready = 1'b0;
    busy     = state == BUILD;
    unique case (state)
      IDLE:    state_d = IDLE;
      BUILD:   if (i == len) state_d = RUN;
      RUN:     in_ready = ~stall;
      default: state_d = IDLE;
    endcase
    // a commit aborts whatever is in flight, including this cycle's symbol
    if (cfg_commit) begin
      state_d  = cfg_ok ? BUILD : IDLE;
      in_ready = 1'b0;
    end
    active = (state == RUN) && !cfg_commit &&
             (stall || (in_valid && in_ready));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (cfg_we && state != BUILD) pat[cfg_idx] <= cfg_char;
    if (cfg_commit) begin
      fail[0] <= '0;
    end else if (step) begin
      if (eq_b)           fail[IDX_W'(i)] <= k + IDX_W'(1);
      else if (k == '0)   fail[IDX_W'(i)] <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len         <= '0;
      i           <= '0;
      k           <= '0;
      j           <= '0;
      stall       <= 1'b0;
      held        <= '0;
      match       <= 1'b0;
      match_count <= '0;
      cfg_error   <= 1'b0;
    end else begin
      match     <= 1'b0;
      cfg_error <= 1'b0;
      if (cfg_commit) begin
        len         <= cfg_len;
        i           <= LEN_W'(1);
        k           <= '0;
        j           <= '0;
        stall       <= 1'b0;
        match_count <= '0;
        cfg_error   <= ~cfg_ok;
      end else if (step) begin
        if (eq_b) begin
          k <= k + IDX_W'(1);
          i <= i + LEN_W'(1);
        end else if (k != '0) begin
          k <= fail[k - IDX_W'(1)];
        end else begin
          i <= i + LEN_W'(1);
        end
      end else if (active) begin
        if (eq_r) begin
          stall <= 1'b0;
          if (last) begin
            match <= 1'b1;
            if (~&match_count) match_count <= match_count + CNT_W'(1);
            j <= overlap_en ? fail_end : '0;
          end else begin
            j <= j + IDX_W'(1);
          end
        end else if (j == '0) begin
          stall <= 1'b0;
        end else begin
          // fall back along the border chain, retrying the same symbol
          j     <= fail[j - IDX_W'(1)];
          held  <= c;
          stall <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_sequence_detector.sv
// Randomized and directed bench for pattern_sequence_detector.
// Reference: sliding-window string comparison on accepted symbols.
module tb_pattern_sequence_detector;
  localparam int CHAR_W  = 8;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 16;
  localparam int IDX_W   = 4;
  localparam int LEN_W   = 5;

  typedef byte bq_t[$];

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_idx = '0;
  logic [CHAR_W-1:0] cfg_char = '0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              cfg_commit = 1'b0;
  logic              overlap_en = 1'b0;
  logic              in_valid = 1'b0;
  logic [CHAR_W-1:0] in_char = '0;
  logic              in_ready, match, cfg_error, busy;
  logic [CNT_W-1:0]  match_count;
  logic              in_ready2, match2, cfg_error2, busy2;
  logic [1:0]        match_count2;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int pulses2 = 0;
  int pbase, pbase2, stalls, mexp_cnt, plen;
  bit last_hit;
  byte pat_m[$];
  byte hist[$];

  pattern_sequence_detector #(
    .CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_char(cfg_char), .cfg_len(cfg_len), .cfg_commit(cfg_commit),
    .overlap_en(overlap_en), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready), .match(match), .match_count(match_count),
    .cfg_error(cfg_error), .busy(busy)
  );

  pattern_sequence_detector #(
    .CHAR_W(CHAR_W), .MAX_LEN(MAX_LEN), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_char(cfg_char), .cfg_len(cfg_len), .cfg_commit(cfg_commit),
    .overlap_en(overlap_en), .in_valid(in_valid), .in_char(in_char),
    .in_ready(in_ready2), .match(match2), .match_count(match_count2),
    .cfg_error(cfg_error2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (match)  pulses++;
    if (match2) pulses2++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input int exp);
    checks++;
    if (got !== 32'(exp)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bq_t q_of(input string s);
    bq_t q;
    for (int n = 0; n < s.len(); n++) q.push_back(s[n]);
    return q;
  endfunction

  task automatic model_reset();
    hist.delete();
    mexp_cnt = 0;
    pbase    = pulses;
    pbase2   = pulses2;
  endtask

  task automatic model_push(input byte ch);
    hist.push_back(ch);
    if (hist.size() > plen) void'(hist.pop_front());
    last_hit = 1'b0;
    if (hist.size() == plen) begin
      last_hit = 1'b1;
      for (int n = 0; n < plen; n++)
        if (hist[n] != pat_m[n]) last_hit = 1'b0;
    end
    if (last_hit) begin
      mexp_cnt++;
      if (!overlap_en) hist.delete();
    end
  endtask

  task automatic wait_build(output int b);
    b = 0;
    while (busy && b < 100) begin
      b++;
      @(negedge clk);
    end
    if (b >= 100) check("build_timeout", 0, 1);
  endtask

  task automatic load(input bq_t p, input bit ov);
    int b;
    for (int n = 0; n < p.size(); n++) begin
      cfg_we   = 1'b1;
      cfg_idx  = IDX_W'(n);
      cfg_char = p[n];
      @(negedge clk);
    end
    cfg_we     = 1'b0;
    cfg_len    = LEN_W'(p.size());
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    overlap_en = ov;
    pat_m      = p;
    plen       = p.size();
    wait_build(b);
    check("build_cycles", 32'(b >= 1 && b <= 2 * plen - 1), 1);
    model_reset();
  endtask

  task automatic send_char(input byte ch);
    int n = 0;
    in_valid = 1'b1;
    in_char  = ch;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      stalls++;
      n++;
    end
    if (n >= 100) check("ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    model_push(ch);
    if (in_ready) check("sym_match", match, int'(last_hit));
  endtask

  task automatic send_str(input string s);
    for (int n = 0; n < s.len(); n++) send_char(s[n]);
  endtask

  task automatic final_check(input string tag);
    repeat (2 * MAX_LEN + 2) @(negedge clk);
    check({tag, "_cnt"}, match_count, mexp_cnt);
    check({tag, "_pulses"}, pulses - pbase, mexp_cnt);
    check({tag, "_sat"}, match_count2, mexp_cnt > 3 ? 3 : mexp_cnt);
    check({tag, "_pulses2"}, pulses2 - pbase2, mexp_cnt);
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_match"}, match, 0);
    check({tag, "_count"}, match_count, 0);
    check({tag, "_error"}, cfg_error, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int b;
    bq_t p;
    repeat (2) @(negedge clk);
    reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 2; t++) begin
      cfg_len    = (t == 0) ? LEN_W'(0) : LEN_W'(MAX_LEN + 1);
      cfg_commit = 1'b1;
      @(negedge clk);
      cfg_commit = 1'b0;
      check("bad_commit_err", cfg_error, 1);
      check("bad_commit_busy", busy, 0);
      check("bad_commit_ready", in_ready, 0);
      @(negedge clk);
      check("bad_commit_pulse", cfg_error, 0);
      check("bad_commit_idle", busy | in_ready, 0);
    end

    load(q_of("VIKHYATH"), 1'b0);
    send_str("XVIKHYATHV");
    final_check("vikhyath");
    check("vikhyath_one", match_count, 1);

    load(q_of("ABAB"), 1'b1);
    send_str("ABABAB");
    final_check("abab_ov");
    check("abab_ov_two", match_count, 2);
    load(q_of("ABAB"), 1'b0);
    send_str("ABABAB");
    final_check("abab_no");
    check("abab_no_one", match_count, 1);

    load(q_of("AAB"), 1'b0);
    stalls = 0;
    send_str("AAAB");
    check("aab_stall", stalls, 1);
    final_check("aab");
    check("aab_one", match_count, 1);

    load(q_of("ABC"), 1'b0);
    send_str("AB");
    in_valid   = 1'b1;
    in_char    = "C";
    cfg_len    = LEN_W'(3);
    cfg_commit = 1'b1;
    #1;
    check("commit_ready", in_ready, 0);
    @(negedge clk);
    cfg_commit = 1'b0;
    in_valid   = 1'b0;
    check("commit_busy", busy, 1);
    check("commit_clear", match_count, 0);
    wait_build(b);
    model_reset();
    send_str("C");
    send_str("ABC");
    final_check("recommit");
    check("recommit_one", match_count, 1);

    load(q_of("AB"), 1'b0);
    send_str("ABABABABAB");
    final_check("sat");
    check("sat_full", match_count, 5);

    load(q_of("AAB"), 1'b0);
    send_str("AA");
    in_valid = 1'b1;
    in_char  = "A";
    @(negedge clk);
    in_valid = 1'b0;
    check("stall_seen", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 10; r++) begin
      int len = $urandom_range(1, 5);
      p.delete();
      for (int n = 0; n < len; n++)
        p.push_back(($urandom % 2) ? 8'h41 : 8'h42);
      load(p, 1'($urandom % 2));
      for (int n = 0; n < 80; n++) begin
        if ($urandom % 4 == 0) @(negedge clk);
        if ($urandom % 10 == 0) send_char("C");
        else send_char(($urandom % 2) ? 8'h41 : 8'h42);
      end
      final_check("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
